// File: rtl/wb_ram_arbiter.sv
// Four-master round-robin Wishbone arbiter in front of a single-port RAM.
// Adds burst-length fairness (yield via retry) and a stalled-strobe timeout.
module wb_ram_arbiter #(
   parameter int dw             = 32,
   parameter int aw             = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int MAX_BEATS      = 16
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_n_i,
   input  logic [4*aw-1:0] wbm_adr_i,
   input  logic [4*dw-1:0] wbm_dat_i,
   input  logic [15:0]     wbm_sel_i,
   input  logic [11:0]     wbm_cti_i,
   input  logic [7:0]      wbm_bte_i,
   input  logic [3:0]      wbm_cyc_i,
   input  logic [3:0]      wbm_stb_i,
   input  logic [3:0]      wbm_we_i,
   output logic [dw-1:0]   wbm_dat_o,
   output logic [3:0]      wbm_ack_o,
   output logic [3:0]      wbm_err_o,
   output logic [3:0]      wbm_rty_o,
   output logic [aw-1:0]   wbs_adr_o,
   output logic [dw-1:0]   wbs_dat_o,
   output logic [3:0]      wbs_sel_o,
   output logic [2:0]      wbs_cti_o,
   output logic [1:0]      wbs_bte_o,
   output logic            wbs_cyc_o,
   output logic            wbs_stb_o,
   output logic            wbs_we_o,
   input  logic [dw-1:0]   wbs_dat_i,
   input  logic            wbs_ack_i,
   input  logic            wbs_err_i,
   output logic [3:0]      grant_o,
   output logic            timeout_o,
   input  logic            timeout_clr_i
);

   typedef enum logic [2:0] {IDLE, OWN, YIELD, TOERR, RELEASE} state_t;

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
   localparam logic [7:0] MB_LIM = 8'(MAX_BEATS);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t     state, state_nxt;
   logic [3:0] grant_nxt;
   logic [1:0] owner, owner_nxt, last_owner, last_owner_nxt;
   logic [1:0] pick, cand;
   logic       found;
   logic [7:0] beat_cnt, beat_nxt, stall_cnt, stall_nxt;
   logic       to_set;
   logic       own_cyc, own_stb, others_req;

   assign own_cyc    = wbm_cyc_i[owner];
   assign own_stb    = wbm_stb_i[owner];
   assign others_req = |(wbm_cyc_i & ~grant_o);
   assign wbm_dat_o  = wbs_dat_i;

   // First requester strictly after last_owner, wrapping 0-1-2-3-0.
   always_comb begin
      pick  = last_owner;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_owner + 2'(k);
         if (!found && wbm_cyc_i[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant_o;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      beat_nxt       = beat_cnt;
      stall_nxt      = 8'd0;
      to_set         = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt      = OWN;
               grant_nxt      = 4'b0001 << pick;
               owner_nxt      = pick;
               last_owner_nxt = pick;
               beat_nxt       = 8'd0;
            end
         end
         OWN: begin
            beat_nxt  = wbs_ack_i ? sat_inc8(beat_cnt) : beat_cnt;
            stall_nxt = (own_stb && !wbs_ack_i && !wbs_err_i) ? sat_inc8(stall_cnt) : 8'd0;
            // Precedence: owner drop, then timeout, then yield.
            if (!own_cyc) begin
               state_nxt = RELEASE;
               grant_nxt = 4'b0000;
            end else if (stall_nxt >= TO_LIM) begin
               state_nxt = TOERR;
               to_set    = 1'b1;
            end else if (beat_nxt >= MB_LIM && others_req) begin
               state_nxt = YIELD;
            end
         end
         YIELD: begin
            if (!own_cyc) begin
               state_nxt = RELEASE;
               grant_nxt = 4'b0000;
            end
         end
         TOERR: begin
            state_nxt = RELEASE;
            grant_nxt = 4'b0000;
         end
         RELEASE: state_nxt = IDLE;
         default: begin
            state_nxt = IDLE;
            grant_nxt = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state      <= IDLE;
         grant_o    <= 4'b0000;
         owner      <= 2'd0;
         last_owner <= 2'd3;
         beat_cnt   <= 8'd0;
         stall_cnt  <= 8'd0;
         timeout_o  <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant_o    <= grant_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         beat_cnt   <= beat_nxt;
         stall_cnt  <= stall_nxt;
         if (to_set)
            timeout_o <= 1'b1;
         else if (timeout_clr_i)
            timeout_o <= 1'b0;
      end
   end

   // Slave-side mux and master-side responses; everything is zero without a grant.
   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_cti_o = '0;
      wbs_bte_o = '0;
      wbs_cyc_o = 1'b0;
      wbs_stb_o = 1'b0;
      wbs_we_o  = 1'b0;
      wbm_ack_o = 4'b0000;
      wbm_err_o = 4'b0000;
      wbm_rty_o = 4'b0000;
      if (|grant_o) begin
         wbs_adr_o = wbm_adr_i[int'(owner)*aw +: aw];
         wbs_dat_o = wbm_dat_i[int'(owner)*dw +: dw];
         wbs_sel_o = wbm_sel_i[int'(owner)*4 +: 4];
         wbs_cti_o = wbm_cti_i[int'(owner)*3 +: 3];
         wbs_bte_o = wbm_bte_i[int'(owner)*2 +: 2];
         wbs_we_o  = wbm_we_i[owner];
         wbs_cyc_o = own_cyc && (state == OWN || state == YIELD);
         wbs_stb_o = own_stb && (state == OWN);
         if (state == OWN && wbs_ack_i)
            wbm_ack_o = grant_o;
         if ((state == OWN && wbs_err_i) || state == TOERR)
            wbm_err_o = grant_o;
         if (state == YIELD && own_stb)
            wbm_rty_o = grant_o;
      end
   end

endmodule

// File: doc/wb_ram_arbiter.md
WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

Interface
REQ-001 SHALL have parameter dw, default 32, data width.
REQ-002 SHALL have parameter aw, default 32, address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, stalled-strobe cycles before forced error (legal 1-255).
REQ-004 SHALL have parameter MAX_BEATS, default 16, acks per grant before yielding if others wait (legal 1-255).
REQ-005 SHALL have ports: wb_clk_i in 1 clock; wb_rst_n_i in 1 reset, asynchronous, active-low.
REQ-006 SHALL have master-side inputs, 4 masters packed, master i in slice i: wbm_adr_i [4*aw], wbm_dat_i [4*dw], wbm_sel_i [16], wbm_cti_i [12], wbm_bte_i [8], wbm_cyc_i [4], wbm_stb_i [4], wbm_we_i [4].
REQ-007 SHALL have master-side outputs: wbm_dat_o dw (broadcast), wbm_ack_o 4, wbm_err_o 4, wbm_rty_o 4.
REQ-008 SHALL have slave-side outputs wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, and inputs wbs_dat_i, wbs_ack_i, wbs_err_i, to the single-port RAM.
REQ-009 SHALL have status outputs: grant_o 4 one-hot current owner; timeout_o 1 sticky timeout flag; timeout_clr_i 1 input clearing it.

Function
REQ-010 SHALL implement states IDLE, OWN, YIELD, TOERR, RELEASE.
REQ-011 IDLE: if any wbm_cyc_i, SHALL register grant to the first requester after last_owner in round-robin order 0-1-2-3-0 and go to OWN; else stay.
REQ-012 OWN: slave-side outputs SHALL equal the owner's slice; when grant_o==0 all slave outputs SHALL be 0.
REQ-013 OWN: wbm_ack_o[i]=wbs_ack_i&grant_o[i], wbm_err_o[i]=wbs_err_i&grant_o[i], combinational; non-owners SHALL see 0.
REQ-014 Owner drops cyc in OWN/YIELD SHALL go to RELEASE, clearing grant_o next edge; RELEASE lasts exactly 1 cycle then IDLE.
REQ-015 Beat counter (8 bit) SHALL reset to 0 on each new grant and increment on each owner ack, saturating at 255.
REQ-016 In OWN, beat count >= MAX_BEATS and any other wbm_cyc_i high SHALL go to YIELD.
REQ-017 YIELD: wbs_stb_o SHALL be 0; wbm_rty_o[owner]=wbm_stb_i[owner] combinationally; state held until owner drops cyc.
REQ-018 Stall counter (8 bit) SHALL count cycles in OWN with owner stb high and wbs_ack_i, wbs_err_i low; SHALL clear on ack, err, or stb low.
REQ-019 Stall count reaching TIMEOUT_CYCLES SHALL go to TOERR; TOERR SHALL force wbs_cyc_o=wbs_stb_o=0, assert wbm_err_o[owner] for exactly 1 cycle, set timeout_o, then go to RELEASE.
REQ-020 Owner-drop takes precedence over yield and timeout in the same cycle; timeout over yield.
REQ-021 last_owner SHALL update on each grant; grant latency from cyc high in IDLE to grant_o is 1 cycle; master switch-over costs 2 idle cycles (RELEASE, IDLE).
REQ-022 timeout_clr_i SHALL clear timeout_o unless a new timeout sets it the same cycle (set wins).
REQ-023 Only one grant_o bit SHALL ever be set; a master SHALL never receive ack/err/rty while not owner.

Reset
REQ-024 wb_rst_n_i low SHALL asynchronously force: state IDLE, grant_o 0, last_owner 3 (master 0 first), counters 0, timeout_o 0, all slave control outputs 0, all ack/err/rty 0.
REQ-025 Reset mid-transfer SHALL abort it with no ack; first post-reset arbitration SHALL favour master 0.

Verification
REQ-026 All four cyc high from reset -> grants in order 0,1,2,3,0 as each drops cyc; grant_o one-hot throughout.
REQ-027 Master 2 alone, 4-beat write burst, sel=4'hF -> 4 acks to master 2, readback data matches, no ack to others.
REQ-028 MAX_BEATS=4, master 0 20-beat burst, master 1 waiting -> rty to master 0 after 4th ack; after drop, master 1 granted 2 cycles later.
REQ-029 TIMEOUT_CYCLES=8, slave ack tied 0 -> wbm_err_o[owner] single pulse 8 cycles after stb, timeout_o=1, cleared by timeout_clr_i.
REQ-030 Reset asserted mid-burst of master 3 -> all outputs 0 immediately; after release, master 0 and 3 requesting -> master 0 granted.
